// File: rtl/digital_monitor_conditioner.sv
// digital_monitor_conditioner: synchronizes the muxed monitor bit and drives the pad as level, stretched pulse or toggle, with a saturating rising-edge counter
// Ports: clk, reset (sync, active-high); monitor_in async monitor bit; conditioner_enable, conditioner_mode (00 level, 01 stretch, 10 toggle, 11 off),
// stretch_len, count_clear; monitor_out registered pad drive; event_count and sticky event_overflow report rising edges since clear.
module digital_monitor_conditioner #(
  parameter int STRETCH_W = 8,
  parameter int COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 monitor_in,
  input  logic                 conditioner_enable,
  input  logic [1:0]           conditioner_mode,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic                 count_clear,
  output logic                 monitor_out,
  output logic [COUNT_W-1:0]   event_count,
  output logic                 event_overflow
);
  logic s1_q, s2_q, s3_q;
  logic out_q, out_d, tog_q, tog_d, ovf_q, ovf_d;
  logic [STRETCH_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] ev_q, ev_d;
  logic rise, stretch_on, toggle_on, sat;
  always_comb begin
    rise       = s2_q & ~s3_q;
    stretch_on = conditioner_enable && conditioner_mode == 2'b01;
    toggle_on  = conditioner_enable && conditioner_mode == 2'b10;
    sat        = &ev_q;
    // a rise reloads the counter even mid-stretch, so retriggers extend the pulse without a gap
    cnt_d = !stretch_on ? '0 : rise ? stretch_len : (cnt_q != '0) ? cnt_q - STRETCH_W'(1) : '0;
    tog_d = toggle_on & (tog_q ^ rise);
    out_d = !conditioner_enable ? 1'b0 :
            conditioner_mode == 2'b00 ? s2_q :
            stretch_on ? (rise | (cnt_q != '0)) :
            toggle_on ? tog_d : 1'b0;
    ev_d  = count_clear ? '0 : (conditioner_enable && rise && !sat) ? ev_q + COUNT_W'(1) : ev_q;
    ovf_d = !count_clear && (ovf_q || (conditioner_enable && rise && sat));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      out_q <= 1'b0;
      tog_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      ev_q  <= '0;
    end else begin
      s1_q  <= monitor_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      out_q <= out_d;
      tog_q <= tog_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      ev_q  <= ev_d;
    end
  end
  assign monitor_out    = out_q;
  assign event_count    = ev_q;
  assign event_overflow = ovf_q;
endmodule
